// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store
// funct3 codes, FSM state encoding and a funct3 legality helper.
package mem_pkg;

    // RV32I memory-access funct3 codes (stores use only the first three)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of the wait-state counter; WAIT_STATES must fit in it
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Loads accept B/H/W/BU/HU; stores accept only B/H/W
    function automatic logic funct3_legal(input logic is_write, input logic [2:0] funct3);
        if (is_write) begin
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads and stores: byte enables, replicated
// store word, extended load data and the misalignment/illegal-funct3 flag.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic        is_write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        access_err
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rdata[8*addr_lo +: 8];
    assign sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Decode access size into lane enables, store replication and load extension
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch)
        byte_en    = 4'b0000;
        wdata_rep  = wdata;
        load_data  = 32'h0000_0000;
        access_err = !funct3_legal(is_write, funct3);

        case (funct3)
            F3_B, F3_BU: begin
                byte_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                load_data = (funct3 == F3_B) ? {{24{sel_byte[7]}}, sel_byte}
                                             : {24'h000000, sel_byte};
            end
            F3_H, F3_HU: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                load_data = (funct3 == F3_H) ? {{16{sel_half[15]}}, sel_half}
                                             : {16'h0000, sel_half};
                if (addr_lo[0]) begin
                    access_err = 1'b1;
                end
            end
            F3_W: begin
                byte_en   = 4'b1111;
                load_data = rdata;
                if (addr_lo != 2'b00) begin
                    access_err = 1'b1;
                end
            end
            default: begin
                access_err = 1'b1;
            end
        endcase

        // Faulted accesses write nothing and return zero; stores return zero too
        if (access_err) begin
            byte_en   = 4'b0000;
            load_data = 32'h0000_0000;
        end
        if (is_write) begin
            load_data = 32'h0000_0000;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage data-memory responder: accepts one load/store, waits
// WAIT_STATES cycles while stalling the pipeline, performs the access and
// pulses Resp_Valid for one cycle.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Valid,
    input  logic        Req_Write,
    input  logic [2:0]  Req_Funct3,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_WData,
    output logic        Req_Ready,
    output logic        Resp_Valid,
    output logic [31:0] Resp_RData,
    output logic        Resp_Error,
    output logic        Stall_M
);

    localparam int               IDX_W         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0]      DEPTH_LIM     = 32'(DEPTH_WORDS);
    localparam logic [WAIT_W-1:0] WAIT_CNT_INIT = WAIT_W'(WAIT_STATES);

    state_t             state;
    state_t             state_next;
    logic [WAIT_W-1:0]  wait_cnt;

    // Request fields captured at acceptance; later Req_* changes are ignored
    logic               req_write_q;
    logic [2:0]         req_funct3_q;
    logic [31:0]        req_addr_q;
    logic [31:0]        req_wdata_q;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               accept;
    logic               access;
    logic               range_err;
    logic [IDX_W-1:0]   word_idx;
    logic [31:0]        raw_word;
    logic [3:0]         byte_en;
    logic [31:0]        wdata_rep;
    logic [31:0]        load_data;
    logic               align_err;
    logic               fault;
    logic               write_en;

    assign accept    = (state == ST_IDLE) && Req_Valid;
    assign access    = (state == ST_BUSY) && (wait_cnt == '0);
    assign range_err = {2'b00, req_addr_q[31:2]} >= DEPTH_LIM;
    assign word_idx  = req_addr_q[IDX_W+1:2];
    assign raw_word  = range_err ? 32'h0000_0000 : mem[word_idx];
    assign fault     = range_err || align_err;
    // A reset landing in the access cycle must also cancel the store
    assign write_en  = access && req_write_q && !fault && !Reset;

    mem_lane_align u_lane_align (
        .is_write   (req_write_q),
        .funct3     (req_funct3_q),
        .addr_lo    (req_addr_q[1:0]),
        .wdata      (req_wdata_q),
        .rdata      (raw_word),
        .byte_en    (byte_en),
        .wdata_rep  (wdata_rep),
        .load_data  (load_data),
        .access_err (align_err)
    );

    // FSM state register
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/stall outputs
    always_comb begin
        state_next = state;
        Req_Ready  = 1'b0;
        Resp_Valid = 1'b0;
        Stall_M    = 1'b0;

        case (state)
            ST_IDLE: begin
                Req_Ready = Req_Valid;
                Stall_M   = Req_Valid;
                if (Req_Valid) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                Stall_M = 1'b1;
                if (wait_cnt == '0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                // Stall drops here so the pipeline advances exactly once
                Resp_Valid = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Wait-state counter: loaded on accept, counts down while busy
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= WAIT_CNT_INIT;
        end else if ((state == ST_BUSY) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Request capture; contents are only used after a fresh accept
    always_ff @(posedge Clk) begin
        if (accept) begin
            req_write_q  <= Req_Write;
            req_funct3_q <= Req_Funct3;
            req_addr_q   <= Req_Addr;
            req_wdata_q  <= Req_WData;
        end
    end

    // Response data/error registered in the access cycle and held afterwards
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Resp_RData <= 32'h0000_0000;
            Resp_Error <= 1'b0;
        end else if (access) begin
            Resp_RData <= fault ? 32'h0000_0000 : load_data;
            Resp_Error <= fault;
        end
    end

    // Byte-lane writes into the storage array
    always_ff @(posedge Clk) begin
        // NOTE: the array has no reset; its contents survive Reset and it maps onto RAM
        for (int i = 0; i < 4; i++) begin
            if (write_en && byte_en[i]) begin
                mem[word_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder. Main instance uses
// WAIT_STATES = 1; a second instance with WAIT_STATES = 0 checks throughput.
module tb_data_mem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_error, stall_m;
    logic [31:0] resp_rdata;

    logic        t0_valid, t0_write;
    logic [2:0]  t0_funct3;
    logic [31:0] t0_addr, t0_wdata;
    logic        t0_ready, t0_resp_valid, t0_resp_error, t0_stall;
    logic [31:0] t0_resp_rdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) dut (
        .Clk        (clk),
        .Reset      (reset),
        .Req_Valid  (req_valid),
        .Req_Write  (req_write),
        .Req_Funct3 (req_funct3),
        .Req_Addr   (req_addr),
        .Req_WData  (req_wdata),
        .Req_Ready  (req_ready),
        .Resp_Valid (resp_valid),
        .Resp_RData (resp_rdata),
        .Resp_Error (resp_error),
        .Stall_M    (stall_m)
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .Clk        (clk),
        .Reset      (reset),
        .Req_Valid  (t0_valid),
        .Req_Write  (t0_write),
        .Req_Funct3 (t0_funct3),
        .Req_Addr   (t0_addr),
        .Req_WData  (t0_wdata),
        .Req_Ready  (t0_ready),
        .Resp_Valid (t0_resp_valid),
        .Resp_RData (t0_resp_rdata),
        .Resp_Error (t0_resp_error),
        .Stall_M    (t0_stall)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One complete access on the WAIT_STATES = 1 instance: accept, count the
    // cycles to Resp_Valid (stall must stay high meanwhile), check the response.
    task automatic do_access(input string tag, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        #1;
        check({tag, ":ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        // Scramble the request after acceptance; the DUT must ignore it
        req_valid  = 1'b0;
        req_write  = ~wr;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFC;
        req_wdata  = 32'hFFFF_FFFF;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = k;
            end else begin
                check({tag, ":stall"}, 32'(stall_m), 32'd1);
            end
        end
        check({tag, ":latency"}, 32'(lat), 32'd3);
        check({tag, ":rdata"}, resp_rdata, exp_rd);
        check({tag, ":error"}, 32'(resp_error), 32'(exp_err));
        check({tag, ":resp_stall"}, 32'(stall_m), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = F3_W;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        t0_valid   = 1'b0;
        t0_write   = 1'b0;
        t0_funct3  = F3_W;
        t0_addr    = 32'h0;
        t0_wdata   = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst:resp_valid", 32'(resp_valid), 32'd0);
        check("rst:rdata", resp_rdata, 32'h0);
        check("rst:error", 32'(resp_error), 32'd0);
        check("rst:ready", 32'(req_ready), 32'd0);
        check("rst:stall", 32'(stall_m), 32'd0);

        // Word store/load round trip
        do_access("sw10", 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        do_access("lw10", 1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte lanes and extension
        do_access("sb13", 1'b1, F3_B, 32'h13, 32'h0000_0080, 32'h0, 1'b0);
        do_access("lb13", 1'b0, F3_B, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0);
        do_access("lbu13", 1'b0, F3_BU, 32'h13, 32'h0, 32'h0000_0080, 1'b0);
        do_access("lw10b", 1'b0, F3_W, 32'h10, 32'h0, 32'h80AD_BEEF, 1'b0);

        // Halfwords and halfword misalignment
        do_access("sh12", 1'b1, F3_H, 32'h12, 32'h0000_1234, 32'h0, 1'b0);
        do_access("lhu12", 1'b0, F3_HU, 32'h12, 32'h0, 32'h0000_1234, 1'b0);
        do_access("lh11", 1'b0, F3_H, 32'h11, 32'h0, 32'h0, 1'b1);
        do_access("lw10c", 1'b0, F3_W, 32'h10, 32'h0, 32'h1234_BEEF, 1'b0);

        // Faulted stores leave memory untouched; range and funct3 errors
        do_access("sw20", 1'b1, F3_W, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
        do_access("sw21", 1'b1, F3_W, 32'h21, 32'h0000_0055, 32'h0, 1'b1);
        do_access("lw20", 1'b0, F3_W, 32'h20, 32'h0, 32'h1122_3344, 1'b0);
        do_access("sh22", 1'b1, F3_H, 32'h22, 32'h0000_8001, 32'h0, 1'b0);
        do_access("lh22", 1'b0, F3_H, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
        do_access("lb20", 1'b0, F3_B, 32'h20, 32'h0, 32'h0000_0044, 1'b0);
        do_access("lw_oor", 1'b0, F3_W, 32'h0000_1000, 32'h0, 32'h0, 1'b1);
        do_access("ld_f3_011", 1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1);
        do_access("st_f3_100", 1'b1, 3'b100, 32'h20, 32'h0000_00FF, 32'h0, 1'b1);
        do_access("lw20b", 1'b0, F3_W, 32'h20, 32'h0, 32'h8001_3344, 1'b0);

        // Response data holds after RESP
        @(negedge clk);
        #1;
        check("hold:resp_valid", 32'(resp_valid), 32'd0);
        check("hold:rdata", resp_rdata, 32'h8001_3344);

        // Reset in the access cycle of a store cancels it
        do_access("sw30", 1'b1, F3_W, 32'h30, 32'h0102_0304, 32'h0, 1'b0);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h30;
        req_wdata  = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rstbusy:resp_valid", 32'(resp_valid), 32'd0);
        check("rstbusy:stall", 32'(stall_m), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstbusy:no_resp", 32'(resp_valid), 32'd0);
        end
        do_access("lw30", 1'b0, F3_W, 32'h30, 32'h0, 32'h0102_0304, 1'b0);

        // Back-to-back requests with WAIT_STATES = 0: IDLE, BUSY, RESP repeating
        @(negedge clk);
        t0_valid  = 1'b1;
        t0_write  = 1'b1;
        t0_funct3 = F3_W;
        t0_addr   = 32'h40;
        t0_wdata  = 32'h0000_0005;
        for (int k = 0; k < 12; k++) begin
            #1;
            check("tput:ready", 32'(t0_ready), 32'((k % 3) == 0));
            check("tput:resp_valid", 32'(t0_resp_valid), 32'((k % 3) == 2));
            check("tput:stall", 32'(t0_stall), 32'((k % 3) != 2));
            @(negedge clk);
        end
        t0_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
